// File: rtl/cog_pkg.sv
// Shared CoG stream definitions: transmitter FSM states, mask byte values
// and the tdata slot layout used by both transmitter and receiver.
package cog_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ACTIVE,
    TX_LINE_GAP,
    TX_FRAME_DONE
  } cog_tx_state_e;

  localparam logic [7:0] MASK_BG  = 8'h00;
  localparam logic [7:0] MASK_FIG = 8'hFF;

  // tdata slots in units of DATA_WIDTH: image in the low half, mask above it
  localparam int unsigned TDATA_IMAGE_SLOT = 0;
  localparam int unsigned TDATA_MASK_SLOT  = 1;

  localparam int unsigned CNT_W = 11;

endpackage

// File: rtl/cog_axis_transmitter_if.sv
// AXI4-Stream video bus carrying {mask, image} beats with tuser/tlast framing.
interface cog_axis_transmitter_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [2*DATA_WIDTH-1:0] tdata;
  logic                    tvalid;
  logic                    tuser;
  logic                    tlast;
  logic                    tready;

  modport master (
    output tdata, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast,
    output tready
  );

endinterface

// File: rtl/cog_axis_out_reg.sv
// Single-entry AXIS output register: loads when empty or draining, holds
// payload stable while stalled.
module cog_axis_out_reg #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_aresetn,
  input  logic                    i_load,
  input  logic [2*DATA_WIDTH-1:0] i_data,
  input  logic                    i_user,
  input  logic                    i_last,
  output logic                    o_slot_free_c,
  cog_axis_transmitter_if.master  m_axis
);

  logic                    r_valid;
  logic [2*DATA_WIDTH-1:0] r_data;
  logic                    r_user;
  logic                    r_last;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_user  <= i_user;
      r_last  <= i_last;
    end else if (m_axis.tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_slot_free_c = !r_valid || m_axis.tready;

  assign m_axis.tvalid = r_valid;
  assign m_axis.tdata  = r_data;
  assign m_axis.tuser  = r_user;
  assign m_axis.tlast  = r_last;

endmodule

// File: rtl/cog_axis_transmitter.sv
// Frame-level CoG AXIS video master: WIDTH x HEIGHT beats per i_start.
// Define COG_TX_LINE_GAP_EN to insert LINE_GAP idle cycles between lines.
module cog_axis_transmitter
  import cog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 1024,
  parameter int unsigned LINE_GAP   = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_aresetn,
  input  logic                   i_start,
  input  logic [DATA_WIDTH-1:0]  i_pix_image,
  input  logic [DATA_WIDTH-1:0]  i_pix_mask,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  cog_axis_transmitter_if.master m_axis,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [CNT_W-1:0]       o_pixel_count,
  output logic [CNT_W-1:0]       o_line_count
);

  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(HEIGHT - 1);

  if (WIDTH < 4 || WIDTH > 2048) begin : g_bad_width
    $error("cog_axis_transmitter: WIDTH out of range");
  end
  if (HEIGHT < 1 || HEIGHT > 2048) begin : g_bad_height
    $error("cog_axis_transmitter: HEIGHT out of range");
  end
  if (LINE_GAP < 1) begin : g_bad_gap
    $error("cog_axis_transmitter: LINE_GAP must be at least 1");
  end

  cog_tx_state_e           r_state;
  cog_tx_state_e           w_state_nxt;
  logic [CNT_W-1:0]        r_pix_cnt;
  logic [CNT_W-1:0]        r_line_cnt;
  logic [CNT_W-1:0]        w_pix_nxt;
  logic [CNT_W-1:0]        w_line_nxt;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    w_busy_nxt;
  logic                    w_done_nxt;
  logic                    w_load;
  logic                    w_slot_free_c;
  logic                    w_user;
  logic                    w_last;
  logic [2*DATA_WIDTH-1:0] w_tdata;

`ifdef COG_TX_LINE_GAP_EN
  localparam int unsigned GAP_W = $clog2(LINE_GAP + 1);
  logic [GAP_W-1:0] r_gap_cnt;

  // Gap counter only runs down once the line's tlast beat has left
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      r_gap_cnt <= '0;
    end else if (r_state == TX_ACTIVE && w_state_nxt == TX_LINE_GAP) begin
      r_gap_cnt <= GAP_W'(LINE_GAP);
    end else if (r_state == TX_LINE_GAP && !m_axis.tvalid && r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - GAP_W'(1);
    end
  end
`endif

  assign w_user = (r_line_cnt == '0) && (r_pix_cnt == '0);
  assign w_last = (r_pix_cnt == PIX_LAST);

  always_comb begin
    w_tdata = '0;
    w_tdata[TDATA_IMAGE_SLOT*DATA_WIDTH +: DATA_WIDTH] = i_pix_image;
    w_tdata[TDATA_MASK_SLOT*DATA_WIDTH +: DATA_WIDTH]  = i_pix_mask;
  end

  // Next-state, counter and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix_cnt;
    w_line_nxt  = r_line_cnt;
    w_busy_nxt  = r_busy && !r_frame_done;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    o_pix_ready = 1'b0;
    unique case (r_state)
      TX_IDLE: begin
        if (i_start) begin
          w_state_nxt = TX_ACTIVE;
          w_busy_nxt  = 1'b1;
        end
      end
      TX_ACTIVE: begin
        o_pix_ready = w_slot_free_c;
        w_load      = i_pix_valid && w_slot_free_c;
        if (w_load) begin
          if (w_last) begin
            w_pix_nxt = '0;
            if (r_line_cnt == LINE_LAST) begin
              w_state_nxt = TX_FRAME_DONE;
            end else begin
              w_line_nxt = r_line_cnt + CNT_W'(1);
`ifdef COG_TX_LINE_GAP_EN
              w_state_nxt = TX_LINE_GAP;
`endif
            end
          end else begin
            w_pix_nxt = r_pix_cnt + CNT_W'(1);
          end
        end
      end
`ifdef COG_TX_LINE_GAP_EN
      TX_LINE_GAP: begin
        if (!m_axis.tvalid && r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt = TX_ACTIVE;
        end
      end
`endif
      TX_FRAME_DONE: begin
        if (w_slot_free_c) begin
          w_done_nxt  = 1'b1;
          w_pix_nxt   = '0;
          w_line_nxt  = '0;
          w_state_nxt = TX_IDLE;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_aresetn) begin
      r_state      <= TX_IDLE;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pix_cnt    <= w_pix_nxt;
      r_line_cnt   <= w_line_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  cog_axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .i_sys_clk     (i_sys_clk),
    .i_sys_aresetn (i_sys_aresetn),
    .i_load        (w_load),
    .i_data        (w_tdata),
    .i_user        (w_user),
    .i_last        (w_last),
    .o_slot_free_c (w_slot_free_c),
    .m_axis        (m_axis)
  );

  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_pixel_count = r_pix_cnt;
  assign o_line_count  = r_line_cnt;

endmodule

// File: tb/tb_cog_axis_transmitter.sv
// Directed self-checking bench for cog_axis_transmitter (8x2 frame, LINE_GAP=3).
module tb_cog_axis_transmitter;
  import cog_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned W    = 8;
  localparam int unsigned H    = 2;
  localparam int unsigned GAP  = 3;
`ifdef COG_TX_LINE_GAP_EN
  localparam int unsigned GAP_CYC = GAP + 1;
`else
  localparam int unsigned GAP_CYC = 0;
`endif
  localparam int unsigned BUSY_CYC = W * H + 2 + GAP_CYC * (H - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [DW-1:0] i_pix_image = '0;
  logic [DW-1:0] i_pix_mask = '0;
  logic          i_pix_valid = 1'b0;
  logic          o_pix_ready;
  logic          o_busy;
  logic          o_frame_done;
  logic [10:0]   o_pixel_count;
  logic [10:0]   o_line_count;

  int n_checks = 0;
  int n_errors = 0;

  cog_axis_transmitter_if #(.DATA_WIDTH(DW)) m_axis ();

  cog_axis_transmitter #(
    .DATA_WIDTH (DW),
    .WIDTH      (W),
    .HEIGHT     (H),
    .LINE_GAP   (GAP)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_aresetn (rst_n),
    .i_start       (i_start),
    .i_pix_image   (i_pix_image),
    .i_pix_mask    (i_pix_mask),
    .i_pix_valid   (i_pix_valid),
    .o_pix_ready   (o_pix_ready),
    .m_axis        (m_axis),
    .o_busy        (o_busy),
    .o_frame_done  (o_frame_done),
    .o_pixel_count (o_pixel_count),
    .o_line_count  (o_line_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask_of(input int p);
    return (p == 0 || p == int'(W) - 1) ? MASK_BG : MASK_FIG;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_tvalid"}, 32'(m_axis.tvalid), 32'd0);
    check_val({tag, "_tdata"},  32'(m_axis.tdata),  32'd0);
    check_val({tag, "_tuser"},  32'(m_axis.tuser),  32'd0);
    check_val({tag, "_tlast"},  32'(m_axis.tlast),  32'd0);
    check_val({tag, "_ready"},  32'(o_pix_ready),   32'd0);
    check_val({tag, "_busy"},   32'(o_busy),        32'd0);
    check_val({tag, "_done"},   32'(o_frame_done),  32'd0);
    check_val({tag, "_pixcnt"}, 32'(o_pixel_count), 32'd0);
    check_val({tag, "_linecnt"},32'(o_line_count),  32'd0);
  endtask

  // Drives one frame cycle by cycle and checks beats, stalls and timing.
  task automatic run_frame(input string tag, input bit stall, input bit restart_mid,
                           input int abort_at, input logic [7:0] base);
    int idx = 0, nbeat = 0, gap_run = 0, gap_len = -1, busy_cyc = 0;
    int done_cnt = 0, done_cyc = -1, last_hs = -1, first_v = -1;
    bit acc_prev = 0, held_v = 0, in_gap = 0;
    logic [15:0] held_d = '0;
    logic held_u = 0, held_l = 0;
    bit timing = !stall && abort_at < 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (acc_prev) idx++;
      i_start       = (cyc == 0) || (restart_mid && cyc == 6);
      i_pix_valid   = 1'b1;
      i_pix_image   = 8'(int'(base) + idx);
      i_pix_mask    = mask_of(idx % int'(W));
      m_axis.tready = stall ? cyc[0] : 1'b1;
      #1;
      if (held_v) begin
        check_val({tag, "_hold_v"}, 32'(m_axis.tvalid), 32'd1);
        check_val({tag, "_hold_d"}, 32'(m_axis.tdata),  32'(held_d));
        check_val({tag, "_hold_u"}, 32'(m_axis.tuser),  32'(held_u));
        check_val({tag, "_hold_l"}, 32'(m_axis.tlast),  32'(held_l));
      end
      if (m_axis.tvalid && first_v < 0) first_v = cyc;
      if (in_gap && m_axis.tvalid) begin
        in_gap = 0;
        gap_len = gap_run;
      end else if (in_gap) begin
        gap_run++;
      end
      if (m_axis.tvalid && m_axis.tready) begin
        check_val({tag, "_data"}, 32'(m_axis.tdata),
                  32'({mask_of(nbeat % int'(W)), 8'(int'(base) + nbeat)}));
        check_val({tag, "_user"}, 32'(m_axis.tuser), 32'(nbeat == 0));
        check_val({tag, "_last"}, 32'(m_axis.tlast), 32'((nbeat % int'(W)) == int'(W) - 1));
        if (nbeat == int'(W) - 1) in_gap = 1;
        nbeat++;
        last_hs = cyc;
      end
      if (o_busy) begin
        busy_cyc++;
        check_val({tag, "_pixcnt"}, 32'(o_pixel_count), 32'(idx % int'(W)));
        if (idx < int'(W * H))
          check_val({tag, "_linecnt"}, 32'(o_line_count), 32'(idx / int'(W)));
      end
      if (o_frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      held_v   = m_axis.tvalid && !m_axis.tready;
      held_d   = m_axis.tdata;
      held_u   = m_axis.tuser;
      held_l   = m_axis.tlast;
      acc_prev = i_pix_valid && o_pix_ready;
      if (abort_at >= 0 && nbeat == abort_at) break;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    i_start = 1'b0;
    check_val({tag, "_first_valid_cyc"}, 32'(first_v), 32'd2);
    if (abort_at < 0) begin
      check_val({tag, "_beats"},     32'(nbeat),    32'(W * H));
      check_val({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
      check_val({tag, "_done_lat"},  32'(done_cyc - last_hs), 32'd1);
    end
    if (timing) begin
      check_val({tag, "_gap"},  32'(gap_len),  32'(GAP_CYC));
      check_val({tag, "_busy"}, 32'(busy_cyc), 32'(BUSY_CYC));
    end
  endtask

  initial begin
    m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("rst");
    rst_n = 1'b1;

    run_frame("base",    1'b0, 1'b0, -1, 8'h00);
    run_frame("stall",   1'b1, 1'b0, -1, 8'h20);
    run_frame("restart", 1'b0, 1'b1, -1, 8'h40);
    run_frame("abort",   1'b0, 1'b0,  6, 8'h60);

    @(negedge clk);
    rst_n       = 1'b0;
    i_pix_valid = 1'b0;
    @(negedge clk);
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("midrst_no_done", 32'(o_frame_done), 32'd0);
    end

    run_frame("post", 1'b0, 1'b0, -1, 8'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cog_axis_transmitter.md
# cog_axis_transmitter

Frame-level AXI4-Stream video master that packs an image byte and a mask byte per pixel into the CoG stream format and emits exactly WIDTH x HEIGHT beats per frame: tuser on the first beat, tlast on the last beat of every line. It is the transmit-side counterpart of the CoG stream receiver and drives the CoG pipeline from a pixel source such as a mask generator or a test-pattern source. It also inserts an optional idle gap between lines, so the downstream receiver sees tvalid fall at every line end.

## Interface
- DATA_WIDTH, 8, width of one image or mask sample
- WIDTH, 1280, pixels per line; valid range 4..2048
- HEIGHT, 1024, lines per frame; valid range 1..2048
- LINE_GAP, 4, idle cycles between lines; valid range ≥1; used only with the gap feature
- i_sys_clk  in  1  the single clock
- i_sys_aresetn  in  1  reset; synchronous, active-low
- i_start  in  1  pulse; arms transmission of one frame
- i_pix_image  in  DATA_WIDTH  upstream image sample
- i_pix_mask  in  DATA_WIDTH  upstream mask sample (0x00 background, 0xFF figure)
- i_pix_valid  in  1  upstream sample valid
- o_pix_ready  out  1  upstream sample accepted when high with i_pix_valid
- m_axis_tdata  out  2*DATA_WIDTH  {mask, image}; mask in the upper half
- m_axis_tvalid  out  1  beat valid
- m_axis_tuser  out  1  start of frame; line 0, pixel 0
- m_axis_tlast  out  1  end of line; pixel WIDTH-1
- m_axis_tready  in  1  downstream ready
- o_busy  out  1  high from i_start acceptance until o_frame_done
- o_frame_done  out  1  one-cycle pulse after the last beat handshake
- o_pixel_count  out  11  index of the next pixel to accept
- o_line_count  out  11  index of the current line

## Operation
- FSM states: IDLE, ACTIVE, LINE_GAP, FRAME_DONE.
- IDLE: counters are 0. When i_start=1, go to ACTIVE and set o_busy=1. i_start is ignored in every other state.
- ACTIVE: o_pix_ready = i_pix_valid-independent (!m_axis_tvalid || m_axis_tready). A transfer happens when i_pix_valid && o_pix_ready.
  - On a transfer, the output register loads {mask, image}. tuser = (line==0 && pixel==0). tlast = (pixel==WIDTH-1). o_pixel_count increments.
  - Transfer of pixel WIDTH-1: o_pixel_count goes to 0.
    - If line==HEIGHT-1, go to FRAME_DONE.
    - Otherwise o_line_count increments, then go to LINE_GAP (gap feature on) or stay in ACTIVE (gap feature off).
- LINE_GAP: o_pix_ready=0. The gap counter loads LINE_GAP on entry and decrements only on cycles with m_axis_tvalid=0. At 0, go to ACTIVE.
- FRAME_DONE: o_pix_ready=0. When the output register is empty (tlast beat handshaken), pulse o_frame_done, clear o_busy, reset the counters, and go to IDLE.
- AXIS rules:
  - tdata, tuser and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - Load and drain in the same cycle is allowed, giving full throughput.
- Upstream i_pix_valid=0 mid-line inserts bubbles. Counts are unaffected.
- Counters are 11 bits. Comparisons use WIDTH-1 and HEIGHT-1 truncated to 11 bits.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, output register empty.
- Reset asserted mid-frame: the frame is abandoned and no o_frame_done is produced. The next i_start produces a fresh frame starting with tuser.
- Latency: a sample accepted at edge k appears with m_axis_tvalid=1 in cycle k+1.
- i_start at edge k: ACTIVE in cycle k+1; first tvalid no earlier than k+2.
- Gap: m_axis_tvalid stays low for ≥LINE_GAP+1 cycles between a tlast handshake and the next line's first beat. It is exactly LINE_GAP+1 when upstream and downstream never stall.
- o_frame_done asserts the cycle after the final handshake. i_start is accepted again the following cycle.

## Configuration
- COG_TX_LINE_GAP_EN defined: the LINE_GAP state and gap counter are compiled in, and lines are separated as above.
- COG_TX_LINE_GAP_EN undefined: LINE_GAP is never entered, and consecutive lines are back-to-back at full throughput. The LINE_GAP parameter is ignored.

## Structure
- The shared package cog_pkg holds:
  - the transmitter state enum typedef
  - MASK_BG (0x00) and MASK_FIG (0xFF)
  - the tdata field offsets used by both transmitter and receiver
- One sub-module: cog_axis_out_reg, the single-entry AXIS output register slice with load/hold/drain and its tvalid/tdata/tuser/tlast storage.

## Test plan
- WIDTH=8, HEIGHT=2, gap on, LINE_GAP=3, tready=1, i_pix_valid=1 -> 16 beats; tuser only on beat 0; tlast on beats 7 and 15; tvalid low exactly 4 cycles between lines; o_frame_done one cycle after beat 15.
- Same setup with tready toggling 1/0 every cycle -> tdata/tuser/tlast stable during stalls; beat order and values identical to the unstalled run.
- Same setup, gap off -> 16 consecutive beats with no tvalid gap; o_busy high for 18 cycles.
- i_start pulsed again mid-frame -> ignored; exactly 16 beats; a single o_frame_done.
- Reset asserted after beat 5 -> next cycle all outputs 0; a new i_start gives beat 0 with tuser=1 and mask/image taken from the first new sample.
- Upstream mask pattern 00,FF,FF,...,FF,00 with image=pixel index -> m_axis_tdata equals {mask, index} per beat; o_pixel_count wraps 7->0.
